// File: rtl/march_c_sequencer.sv
// March C- BIST sequencer: drives one RAM operation per clock through the six
// March elements and records the first read mismatch (address and element).
module march_c_sequencer #(
    parameter int size   = 8,
    parameter int length = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [length-1:0] mem_dout,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [size-1:0]   mem_addr,
    output logic [length-1:0] mem_din,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [size-1:0]   fail_addr,
    output logic [2:0]        fail_elem
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [size-1:0] ADDR_LAST = {size{1'b1}};
    localparam logic [size-1:0] ADDR_ONE  = {{(size-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              wr_phase_q, wr_phase_d;
    logic [size-1:0]   addr_d;
    logic              op_valid;

    logic              mem_cs_q, mem_cs_d;
    logic              mem_rwbar_q, mem_rwbar_d;
    logic [size-1:0]   mem_addr_q, mem_addr_d;
    logic [length-1:0] mem_din_q, mem_din_d;

    logic              fail_q, fail_d;
    logic [size-1:0]   fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    // Two-stage compare pipeline: stage 0 loads with the read launch,
    // stage 1 lines up with mem_dout one cycle after the RAM captures it.
    logic [1:0]        pv_q, pv_d;
    logic [1:0]        pones_q, pones_d;
    logic [2:0]        pelem_q [2];
    logic [2:0]        pelem_d [2];
    logic [size-1:0]   paddr_q [2];
    logic [size-1:0]   paddr_d [2];

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        wr_phase_d = wr_phase_q;
        addr_d     = mem_addr_q;
        op_valid   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    op_valid   = 1'b1;
                    elem_d     = 3'd0;
                    addr_d     = '0;
                    wr_phase_d = 1'b1;
                end
            end
            RUN: begin
                op_valid = 1'b1;
                case (elem_q)
                    3'd0: begin
                        if (mem_addr_q == ADDR_LAST) begin
                            elem_d     = 3'd1;
                            addr_d     = '0;
                            wr_phase_d = 1'b0;
                        end else begin
                            addr_d = mem_addr_q + ADDR_ONE;
                        end
                    end
                    3'd1, 3'd2: begin
                        if (!wr_phase_q) begin
                            wr_phase_d = 1'b1;
                        end else if (mem_addr_q == ADDR_LAST) begin
                            elem_d     = elem_q + 3'd1;
                            wr_phase_d = 1'b0;
                            addr_d     = (elem_q == 3'd1) ? '0 : ADDR_LAST;
                        end else begin
                            addr_d     = mem_addr_q + ADDR_ONE;
                            wr_phase_d = 1'b0;
                        end
                    end
                    3'd3, 3'd4: begin
                        if (!wr_phase_q) begin
                            wr_phase_d = 1'b1;
                        end else if (mem_addr_q == '0) begin
                            elem_d     = elem_q + 3'd1;
                            wr_phase_d = 1'b0;
                            addr_d     = (elem_q == 3'd3) ? ADDR_LAST : '0;
                        end else begin
                            addr_d     = mem_addr_q - ADDR_ONE;
                            wr_phase_d = 1'b0;
                        end
                    end
                    default: begin
                        wr_phase_d = 1'b0;
                        if (mem_addr_q == ADDR_LAST) begin
                            op_valid = 1'b0;
                            state_d  = FLUSH;
                            addr_d   = '0;
                        end else begin
                            addr_d = mem_addr_q + ADDR_ONE;
                        end
                    end
                endcase
            end
            FLUSH: state_d = DONE;
            default: state_d = IDLE;
        endcase

        mem_cs_d    = op_valid;
        mem_rwbar_d = !(op_valid && wr_phase_d);
        mem_addr_d  = op_valid ? addr_d : '0;
        mem_din_d   = (op_valid && wr_phase_d && (elem_d == 3'd1 || elem_d == 3'd3))
                      ? {length{1'b1}} : {length{1'b0}};

        pv_d[0]    = op_valid && !wr_phase_d;
        pones_d[0] = (elem_d == 3'd2) || (elem_d == 3'd4);
        pelem_d[0] = elem_d;
        paddr_d[0] = addr_d;
        pv_d[1]    = pv_q[0];
        pones_d[1] = pones_q[0];
        pelem_d[1] = pelem_q[0];
        paddr_d[1] = paddr_q[0];

        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (pv_q[1] && (mem_dout != {length{pones_q[1]}})) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = paddr_q[1];
                fail_elem_d = pelem_q[1];
            end
        end
        // A relaunch from DONE starts a fresh result; the pipeline is empty then.
        if ((state_q == IDLE || state_q == DONE) && start) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= 3'd0;
            wr_phase_q  <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_rwbar_q <= 1'b1;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            pv_q        <= 2'b00;
            pones_q     <= 2'b00;
            pelem_q     <= '{default: '0};
            paddr_q     <= '{default: '0};
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            wr_phase_q  <= wr_phase_d;
            mem_cs_q    <= mem_cs_d;
            mem_rwbar_q <= mem_rwbar_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            pv_q        <= pv_d;
            pones_q     <= pones_d;
            pelem_q     <= pelem_d;
            paddr_q     <= paddr_d;
        end
    end

    assign mem_cs    = mem_cs_q;
    assign mem_rwbar = mem_rwbar_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign busy      = (state_q == RUN) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_march_c_sequencer.sv
// Directed bench for march_c_sequencer: 256-word and 16-word instances, each
// talking to a synchronous-read RAM model; the 256-word RAM can inject stuck-at bits.
module tb_march_c_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] dout8 = '0;
    logic [7:0] dout4 = '0;

    logic       cs8, rw8, busy8, done8, fail8;
    logic [7:0] addr8, din8, faddr8;
    logic [2:0] felem8;
    logic       cs4, rw4, busy4, done4, fail4;
    logic [3:0] addr4, faddr4;
    logic [7:0] din4;
    logic [2:0] felem4;

    march_c_sequencer #(.size(8), .length(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mem_dout(dout8),
        .mem_cs(cs8), .mem_rwbar(rw8), .mem_addr(addr8), .mem_din(din8),
        .busy(busy8), .done(done8), .fail(fail8), .fail_addr(faddr8), .fail_elem(felem8)
    );

    march_c_sequencer #(.size(4), .length(8)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mem_dout(dout4),
        .mem_cs(cs4), .mem_rwbar(rw4), .mem_addr(addr4), .mem_din(din4),
        .busy(busy4), .done(done4), .fail(fail4), .fail_addr(faddr4), .fail_elem(felem4)
    );

    logic [7:0] ram8 [256];
    logic [7:0] ram4 [16];
    logic       sa1_on = 1'b0;   // addr 0x05 bit 3 stuck at 1
    logic       sa0_on = 1'b0;   // addr 0xFF bit 0 stuck at 0

    function automatic logic [7:0] ram8_read(input logic [7:0] a);
        logic [7:0] v;
        v = ram8[a];
        if (sa1_on && a == 8'h05) v[3] = 1'b1;
        if (sa0_on && a == 8'hFF) v[0] = 1'b0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (cs8 && !rw8) ram8[addr8] <= din8;
        if (cs8 && rw8)  dout8 <= ram8_read(addr8);
        if (cs4 && !rw4) ram4[addr4] <= din4;
        if (cs4 && rw4)  dout4 <= ram4[addr4];
    end

    int total = 0;
    int bad   = 0;

    // Expected op i of a March C- run over n words, by index arithmetic.
    function automatic void exp_op(input int n, input int i, output logic rw,
                                   output int a, output int d);
        int j, e, r;
        if (i < n) begin
            rw = 1'b0; a = i; d = 0;
        end else if (i < 9 * n) begin
            j  = i - n;
            e  = 1 + j / (2 * n);
            r  = j % (2 * n);
            a  = (e <= 2) ? r / 2 : n - 1 - r / 2;
            rw = (r % 2 == 0);
            d  = (!rw && (e == 1 || e == 3)) ? 255 : 0;
        end else begin
            rw = 1'b1; a = i - 9 * n; d = 0;
        end
    endfunction

    task automatic launch8();
        @(negedge clk); start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
    endtask

    // Runs one full 256-word test checking every op, launch-edge clearing and
    // end timing; optionally pulses start while busy and checks the fail edge.
    task automatic run_ops8(input int mid_start, input int fail_edge);
        logic erw;
        int   ea, ed, ncs;
        ncs = 0;
        launch8();
        for (int i = 0; i <= 2561; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            start8 = (i == mid_start);
            ncs += int'(cs8);
            if (i == 0) begin
                total++;
                if (busy8 !== 1'b1 || done8 !== 1'b0 || fail8 !== 1'b0 || faddr8 !== 8'h00 || felem8 !== 3'd0) begin
                    bad++;
                    $display("FAIL launch8: busy=%b done=%b fail=%b faddr=%h felem=%0d want 1 0 0 00 0", busy8, done8, fail8, faddr8, felem8);
                end
            end
            if (i < 2560) begin
                exp_op(256, i, erw, ea, ed);
                total++;
                if (cs8 !== 1'b1 || rw8 !== erw || addr8 !== ea[7:0] || (!erw && din8 !== ed[7:0])) begin
                    bad++;
                    $display("FAIL op%0d: cs=%b rw=%b addr=%h din=%h want cs=1 rw=%b addr=%h din=%h", i, cs8, rw8, addr8, din8, erw, ea[7:0], ed[7:0]);
                end
            end
            if (i == 2560) begin
                total++;
                if (cs8 !== 1'b0 || rw8 !== 1'b1 || busy8 !== 1'b1 || done8 !== 1'b0) begin
                    bad++;
                    $display("FAIL flush8: cs=%b rw=%b busy=%b done=%b want 0 1 1 0", cs8, rw8, busy8, done8);
                end
            end
            if (i == 2561) begin
                total++;
                if (done8 !== 1'b1 || busy8 !== 1'b0 || cs8 !== 1'b0) begin
                    bad++;
                    $display("FAIL done8: done=%b busy=%b cs=%b want 1 0 0", done8, busy8, cs8);
                end
            end
            if (fail_edge > 0 && (i == fail_edge - 1 || i == fail_edge)) begin
                total++;
                if (fail8 !== (i == fail_edge)) begin
                    bad++;
                    $display("FAIL fail_edge@%0d: fail=%b want %b", i, fail8, (i == fail_edge));
                end
            end
        end
        start8 = 1'b0;
        total++;
        if (ncs != 2560) begin
            bad++;
            $display("FAIL cs_count8: got %0d want 2560", ncs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cs8 !== 1'b0 || rw8 !== 1'b1 || addr8 !== 8'h00 || din8 !== 8'h00 || busy8 !== 1'b0 ||
            done8 !== 1'b0 || fail8 !== 1'b0 || faddr8 !== 8'h00 || felem8 !== 3'd0) begin
            bad++;
            $display("FAIL reset8: cs=%b rw=%b addr=%h din=%h busy=%b done=%b fail=%b fa=%h fe=%0d want 0 1 00 00 0 0 0 00 0",
                     cs8, rw8, addr8, din8, busy8, done8, fail8, faddr8, felem8);
        end
        total++;
        if (cs4 !== 1'b0 || rw4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL reset4: cs=%b rw=%b busy=%b done=%b want 0 1 0 0", cs4, rw4, busy4, done4);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_fault_free();
        sa1_on = 1'b0; sa0_on = 1'b0;
        run_ops8(-1, -1);
        total++;
        if (fail8 !== 1'b0) begin
            bad++;
            $display("FAIL fault_free: fail=%b want 0", fail8);
        end
        $display("test_fault_free done");
    endtask

    task automatic test_stuck_at_1();
        sa1_on = 1'b1; sa0_on = 1'b0;
        run_ops8(-1, 268);
        total++;
        if (done8 !== 1'b1 || fail8 !== 1'b1 || faddr8 !== 8'h05 || felem8 !== 3'd1) begin
            bad++;
            $display("FAIL sa1_result: done=%b fail=%b fa=%h fe=%0d want 1 1 05 1", done8, fail8, faddr8, felem8);
        end
        $display("test_stuck_at_1 done");
    endtask

    task automatic test_stuck_at_0();
        sa1_on = 1'b0; sa0_on = 1'b1;
        run_ops8(-1, 1280);
        total++;
        if (done8 !== 1'b1 || fail8 !== 1'b1 || faddr8 !== 8'hFF || felem8 !== 3'd2) begin
            bad++;
            $display("FAIL sa0_result: done=%b fail=%b fa=%h fe=%0d want 1 1 ff 2", done8, fail8, faddr8, felem8);
        end
        $display("test_stuck_at_0 done");
    endtask

    task automatic test_restart_clean();
        sa1_on = 1'b0; sa0_on = 1'b0;
        run_ops8(-1, -1);
        total++;
        if (done8 !== 1'b1 || fail8 !== 1'b0 || faddr8 !== 8'h00 || felem8 !== 3'd0) begin
            bad++;
            $display("FAIL restart: done=%b fail=%b fa=%h fe=%0d want 1 0 00 0", done8, fail8, faddr8, felem8);
        end
        $display("test_restart_clean done");
    endtask

    task automatic test_start_while_busy();
        run_ops8(1000, -1);
        $display("test_start_while_busy done");
    endtask

    task automatic test_small();
        logic erw;
        int   ea, ed, ncs;
        ncs = 0;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        for (int i = 0; i <= 161; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ncs += int'(cs4);
            if (i < 160) begin
                exp_op(16, i, erw, ea, ed);
                total++;
                if (cs4 !== 1'b1 || rw4 !== erw || addr4 !== ea[3:0] || (!erw && din4 !== ed[7:0])) begin
                    bad++;
                    $display("FAIL small_op%0d: cs=%b rw=%b addr=%h din=%h want cs=1 rw=%b addr=%h din=%h", i, cs4, rw4, addr4, din4, erw, ea[3:0], ed[7:0]);
                end
            end
            if (i == 160 || i == 161) begin
                total++;
                if (busy4 !== (i == 160) || done4 !== (i == 161)) begin
                    bad++;
                    $display("FAIL small_end@%0d: busy=%b done=%b want %b %b", i, busy4, done4, (i == 160), (i == 161));
                end
            end
        end
        total++;
        if (ncs != 160 || fail4 !== 1'b0) begin
            bad++;
            $display("FAIL small_count: cs=%0d fail=%b want 160 0", ncs, fail4);
        end
        $display("test_small done");
    endtask

    task automatic test_reset_midrun();
        sa1_on = 1'b1; sa0_on = 1'b0;
        launch8();
        repeat (700) begin @(posedge clk); #1; end
        total++;
        if (fail8 !== 1'b1 || busy8 !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pre: fail=%b busy=%b want 1 1", fail8, busy8);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (cs8 !== 1'b0 || rw8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || fail8 !== 1'b0 || faddr8 !== 8'h00) begin
            bad++;
            $display("FAIL midrun_rst: cs=%b rw=%b busy=%b done=%b fail=%b fa=%h want 0 1 0 0 0 00", cs8, rw8, busy8, done8, fail8, faddr8);
        end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (cs8 !== 1'b0 || busy8 !== 1'b0 || fail8 !== 1'b0) begin
            bad++;
            $display("FAIL midrun_idle: cs=%b busy=%b fail=%b want 0 0 0", cs8, busy8, fail8);
        end
        $display("test_reset_midrun done");
    endtask

    // Reset lands while the faulty read of 0x05 is still in the compare pipeline.
    task automatic test_reset_flush();
        sa1_on = 1'b1; sa0_on = 1'b0;
        launch8();
        repeat (266) begin @(posedge clk); #1; end
        total++;
        if (cs8 !== 1'b1 || rw8 !== 1'b1 || addr8 !== 8'h05) begin
            bad++;
            $display("FAIL flush_pre: cs=%b rw=%b addr=%h want 1 1 05", cs8, rw8, addr8);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (fail8 !== 1'b0 || faddr8 !== 8'h00) begin
            bad++;
            $display("FAIL flush_post: fail=%b fa=%h want 0 00", fail8, faddr8);
        end
        sa1_on = 1'b0;
        $display("test_reset_flush done");
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at_1();
        test_stuck_at_0();
        test_restart_clean();
        test_start_while_busy();
        test_small();
        test_reset_midrun();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
